ifstage: RTL

Instruction fetch stage of the rv32i pipeline, directly upstream of the decode stage. Owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small FIFO. Presents one 32-bit instruction per cycle to decode. Supports downstream stall and a redirect (branch/jump target) that flushes all in-flight and buffered fetches.

---
 rtl/ifstage.sv | 107 ++++++++++
 1 files changed

// File: rtl/ifstage.sv
// rtl/ifstage.sv - rv32i instruction fetch stage with in-order request tagging and output FIFO
// Owns the PC, fetches over req/gnt/rvalid, and hands one buffered instruction per cycle to decode.
module ifstage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] occupancy;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_word [DEPTH];
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] fifo_wr;
  logic [31:0]   ifl_pc    [DEPTH];
  logic [AW-1:0] ifl_rd;
  logic [AW-1:0] ifl_wr;

  logic [CW:0] in_use;
  logic        grant;
  logic        resp;
  logic        keep;
  logic        pop;

  assign valid_o = (occupancy != '0);
  assign pop     = valid_o && !stall_i && !redirect_i;

  // Slot accounting credits this cycle's pop so a zero-wait memory streams one word per cycle.
  assign in_use = {1'b0, occupancy} + {1'b0, outstanding - discard} - {{CW{1'b0}}, pop};

  assign imem_req_o  = !rst_i && !redirect_i && (in_use < DEPTH_S) && ({1'b0, outstanding} < DEPTH_S);
  assign imem_addr_o = fetch_pc;

  assign grant = imem_req_o && imem_gnt_i;
  assign resp  = imem_rvalid_i && (outstanding != '0);
  assign keep  = resp && (discard == '0) && !redirect_i;

  assign instruction_o = valid_o ? fifo_word[fifo_rd] : NOP;
  assign pc_o          = valid_o ? fifo_pc[fifo_rd]   : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      occupancy   <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      ifl_rd      <= '0;
      ifl_wr      <= '0;
    end else begin
      if (redirect_i)
        fetch_pc <= redirect_pc_i & ~32'h3;
      else if (grant)
        fetch_pc <= fetch_pc + 32'd4;

      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (grant) ifl_wr <= ifl_wr + 1'b1;
      if (resp)  ifl_rd <= ifl_rd + 1'b1;

      // Everything granted before a redirect and still in flight belongs to the old path.
      if (redirect_i)
        discard <= outstanding - CW'(resp);
      else if (resp && (discard != '0))
        discard <= discard - 1'b1;

      if (redirect_i) begin
        fifo_rd   <= '0;
        fifo_wr   <= '0;
        occupancy <= '0;
      end else begin
        if (keep) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        occupancy <= occupancy + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) ifl_pc[ifl_wr] <= fetch_pc;
    if (keep) begin
      fifo_pc[fifo_wr]   <= ifl_pc[ifl_rd];
      fifo_word[fifo_wr] <= imem_rdata_i;
    end
  end

endmodule
